// File: rtl/product_display_pkg.sv
// Shared definitions for the product display block.
// Holds the FSM state type, the 7-segment pattern table, the blank pattern,
// the double-dabble iteration count and the per-iteration nibble adjust.
package product_display_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  // Number of shift/adjust iterations for an 8-bit binary input.
  localparam int unsigned ITER = 8;

  // Active-low, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digits 0..9. Codes 10..15 decode as blank so an out-of-range nibble
  // never lights a misleading glyph.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000,
    SEG_BLANK,  SEG_BLANK,  SEG_BLANK,  SEG_BLANK,
    SEG_BLANK,  SEG_BLANK
  };

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more,
  // so the following left shift carries correctly into the next decade.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/product_display_seg7_decode.sv
// Combinational 7-segment decoder.
// Ports:
//   nibble_i : BCD digit to show
//   blank_i  : force all segments off
//   seg_o    : active-low segments, seg_o[0]=a .. seg_o[6]=g
module seg7_decode
  import product_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_BLANK : SEG_TABLE[nibble_i];
  end

endmodule

// File: rtl/product_display.sv
// Converts an 8-bit product to BCD with a sequential double-dabble and
// scans the result onto a 4-digit multiplexed 7-segment display.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   p, load  : product value and one-cycle capture strobe
//   busy     : conversion in progress
//   bcd      : last completed result {hundreds, tens, units}
//   seg, an  : active-low segments and digit anodes (an[0] = units)
module product_display
  import product_display_pkg::*;
#(
  parameter int unsigned REFRESH_CNT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  p,
  input  logic        load,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned CW = $clog2(REFRESH_CNT);

  state_e      state_q, state_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [11:0] scratch_q, scratch_d;
  logic [3:0]  iter_q, iter_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;
  logic [19:0] shifted;

  logic [CW-1:0] refresh_q;
  logic [1:0]    idx_q;

  logic [3:0] digit_nib;
  logic       digit_blank;

  // Conversion FSM and datapath.
  always_comb begin
    adj     = dabble_adjust(scratch_q);
    shifted = {adj, shreg_q} << 1;
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = p;
          scratch_d = '0;
          iter_d    = '0;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = shifted[19:8];
        shreg_d   = shifted[7:0];
        iter_d    = iter_q + 4'd1;
        // Result is published on the final iteration edge from the freshly
        // shifted scratch, so bcd only ever changes to a complete value.
        if (iter_q == 4'(ITER - 1)) begin
          bcd_d   = shifted[19:8];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      bcd_q     <= bcd_d;
    end
  end

  // Display scan: free-running, independent of the conversion FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_q <= '0;
      idx_q     <= '0;
    end else if (refresh_q == CW'(REFRESH_CNT - 1)) begin
      refresh_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  always_comb begin
    an          = 4'b1111;
    digit_nib   = '0;
    digit_blank = 1'b1;
    unique case (idx_q)
      2'd0: begin
        an          = 4'b1110;
        digit_nib   = bcd_q[3:0];
        digit_blank = 1'b0;
      end
      2'd1: begin
        an          = 4'b1101;
        digit_nib   = bcd_q[7:4];
        digit_blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        an          = 4'b1011;
        digit_nib   = bcd_q[11:8];
        digit_blank = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        an          = 4'b1111;
        digit_nib   = '0;
        digit_blank = 1'b1;
      end
    endcase
  end

  seg7_decode u_seg7_decode (
    .nibble_i (digit_nib),
    .blank_i  (digit_blank),
    .seg_o    (seg)
  );

  assign busy = (state_q == CONV);
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_product_display.sv
// Directed self-checking bench for product_display with REFRESH_CNT=4.
module tb_product_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  p;
  logic        load;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;   // cycles since the last reset edge
  logic [11:0] mbcd;        // bcd value the display should currently show

  always #5 clk = ~clk;

  product_display #(.REFRESH_CNT(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .p    (p),
    .load (load),
    .busy (busy),
    .bcd  (bcd),
    .seg  (seg),
    .an   (an)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check_scan(input string tag);
    int unsigned k;
    logic [3:0] ean;
    logic [6:0] eseg;
    k = (cyc / 4) % 4;
    case (k)
      0: begin ean = 4'b1110; eseg = digit_seg(mbcd[3:0]); end
      1: begin
        ean  = 4'b1101;
        eseg = (mbcd[11:4] == 8'h00) ? 7'b1111111 : digit_seg(mbcd[7:4]);
      end
      2: begin
        ean  = 4'b1011;
        eseg = (mbcd[11:8] == 4'h0) ? 7'b1111111 : digit_seg(mbcd[11:8]);
      end
      default: begin ean = 4'b1111; eseg = 7'b1111111; end
    endcase
    check({tag, "_an"}, {28'd0, an}, {28'd0, ean});
    check({tag, "_seg"}, {25'd0, seg}, {25'd0, eseg});
  endtask

  task automatic scan_cycles(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check_scan(tag);
      tick();
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    cyc  = 0;
    mbcd = '0;
  endtask

  task automatic do_load(input logic [7:0] v);
    p    = v;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    p    = '0;
    do_reset();

    // Reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bcd", {20'd0, bcd}, 32'h000);
    check("rst_an", {28'd0, an}, 32'b1110);
    check("rst_seg", {25'd0, seg}, 32'b1000000);

    // p=0: scan with blanking, continuing through the conversion
    do_load(8'd0);
    scan_cycles("scan_p0", 16);
    check("p0_bcd", {20'd0, bcd}, 32'h000);
    check("p0_busy", {31'd0, busy}, 32'd0);

    // p=225: busy for exactly 8 cycles, old bcd held, scan unaffected
    do_load(8'd225);
    check("p225_busy0", {31'd0, busy}, 32'd1);
    for (int unsigned i = 1; i < 8; i++) begin
      tick();
      check("p225_busy", {31'd0, busy}, 32'd1);
      check("p225_hold", {20'd0, bcd}, 32'h000);
      check_scan("p225_scan");
    end
    tick();
    mbcd = 12'h225;
    check("p225_bcd", {20'd0, bcd}, 32'h225);
    check("p225_done", {31'd0, busy}, 32'd0);
    scan_cycles("scan_225", 16);

    // p=9: hundreds and tens blanked
    do_load(8'd9);
    repeat (7) tick();
    check("p9_busy", {31'd0, busy}, 32'd1);
    tick();
    mbcd = 12'h009;
    check("p9_bcd", {20'd0, bcd}, 32'h009);
    check("p9_done", {31'd0, busy}, 32'd0);
    scan_cycles("scan_9", 16);

    // p=100, then p=50 three cycles later is ignored
    do_load(8'd100);
    tick();
    tick();
    do_load(8'd50);
    check("ign_busy", {31'd0, busy}, 32'd1);
    repeat (4) tick();
    check("ign_busy7", {31'd0, busy}, 32'd1);
    check("ign_hold", {20'd0, bcd}, 32'h009);
    tick();
    mbcd = 12'h100;
    check("ign_bcd", {20'd0, bcd}, 32'h100);
    check("ign_done", {31'd0, busy}, 32'd0);
    repeat (4) tick();
    check("ign_noq_busy", {31'd0, busy}, 32'd0);
    check("ign_noq_bcd", {20'd0, bcd}, 32'h100);

    // Reset after 4 iterations of p=200 aborts, no partial write
    do_load(8'd200);
    repeat (4) tick();
    rst  = 1'b1;
    load = 1'b1;
    p    = 8'd77;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    cyc  = 0;
    mbcd = '0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_bcd", {20'd0, bcd}, 32'h000);
    check("abort_an", {28'd0, an}, 32'b1110);
    check("abort_seg", {25'd0, seg}, 32'b1000000);

    // Reset wins over load in IDLE
    rst  = 1'b1;
    load = 1'b1;
    p    = 8'd77;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    cyc  = 0;
    check("prio_busy", {31'd0, busy}, 32'd0);
    tick();
    check("prio_busy2", {31'd0, busy}, 32'd0);
    check("prio_bcd", {20'd0, bcd}, 32'h000);

    do_load(8'd200);
    repeat (8) tick();
    mbcd = 12'h200;
    check("p200_bcd", {20'd0, bcd}, 32'h200);
    check("p200_done", {31'd0, busy}, 32'd0);
    scan_cycles("scan_200", 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/product_display.md
PRODUCT_DISPLAY -- requirements
Module: product_display

Interface
REQ-001 SHALL have parameter REFRESH_CNT, default 100000, meaning clock cycles per displayed digit (1 ms at 100 MHz); legal range ≥2.
REQ-002 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  meaning synchronous, active-high reset.
REQ-004 SHALL have port p  in  8  meaning the unsigned product from the 4x4 multiplier stage (0..225).
REQ-005 SHALL have port load  in  1  meaning a one-cycle strobe: capture p and start conversion.
REQ-006 SHALL have port busy  out  1  meaning conversion in progress.
REQ-007 SHALL have port bcd  out  12  meaning the last completed result {hundreds, tens, units}, 4 bits each.
REQ-008 SHALL have port seg  out  7  meaning active-low segments; seg[0]=a … seg[6]=g.
REQ-009 SHALL have port an  out  4  meaning active-low digit anodes; an[0]=units.

Function
REQ-010 SHALL implement the FSM states IDLE and CONV.
REQ-011 IDLE with load=1 at edge k SHALL latch p into a shift register, clear the 12-bit scratch BCD and the iteration counter, and go to CONV.
REQ-012 CONV SHALL perform one double-dabble iteration per cycle: add 3 to every scratch nibble ≥5, then shift {scratch, shift reg} left by one bit.
REQ-013 CONV SHALL finish on the 8th iteration (edge k+8), write the completed scratch into bcd atomically at that same edge, and return to IDLE.
REQ-014 bcd SHALL never show a partial result.
REQ-015 busy SHALL be high exactly while the FSM is in CONV, i.e. 8 cycles.
REQ-016 The earliest next load SHALL be accepted at edge k+9.
REQ-017 load while busy=1 SHALL be ignored; it SHALL neither queue nor restart the conversion.
REQ-018 The refresh counter SHALL count 0..REFRESH_CNT-1 and wrap.
REQ-019 On each wrap the 2-bit digit index SHALL advance 0→1→2→3→0.
REQ-020 an/seg SHALL be decoded combinationally from the digit index and bcd, as follows:
  - idx0: an=1110, units digit
  - idx1: an=1101, tens digit
  - idx2: an=1011, hundreds digit
  - idx3: an=1111, seg=1111111 (unused slot)
REQ-021 Leading-zero blanking: the hundreds digit SHALL be blanked when it is 0.
REQ-022 Leading-zero blanking: the tens digit SHALL be blanked when hundreds=0 and tens=0.
REQ-023 Leading-zero blanking: the units digit SHALL always be shown.
REQ-024 A blanked digit SHALL drive seg=1111111 with its anode still asserted.
REQ-025 Nibble values 10..15 SHALL NOT occur; if forced, the decoder SHALL output seg=1111111.
REQ-026 The display scan SHALL continue unaffected during conversion and SHALL show the old bcd until it is updated.

Reset
REQ-027 rst=1 SHALL set the state to IDLE, busy=0, bcd=12'h000, scratch, shift reg and counters to 0, and digit index to 0.
REQ-028 Immediately after reset, an SHALL be 1110 and seg SHALL be 1000000 ("0").
REQ-029 rst asserted mid-CONV SHALL abort the conversion, with bcd=000 and no partial write.
REQ-030 rst SHALL take priority over load on the same edge.

Structure
REQ-031 Shared package product_display_pkg SHALL hold the state enum, the SEG_BLANK constant (7'b1111111), the digit-0..9 segment pattern table and the ITER constant (8).
REQ-032 One sub-module seg7_decode (4-bit nibble + blank → seg[6:0], combinational) SHALL be used.
REQ-033 The FSM, double-dabble datapath and scan counter SHALL remain in product_display.

Verification (bench uses REFRESH_CNT=4)
REQ-034 Load p=225 → busy=1 for exactly 8 cycles, bcd=12'h225 at edge k+8, busy=0 on the following cycle.
REQ-035 After reset, load p=0 → bcd=000; scan shows an=1110 seg=1000000, then an=1101/1011 with seg=1111111, then an=1111.
REQ-036 Load p=9 → bcd=009; the hundreds and tens digits are blanked and units seg=0010000.
REQ-037 Load p=100, then load p=50 three cycles later → the second load is ignored and bcd=12'h100 after 8 cycles.
REQ-038 rst after 4 iterations of a p=200 conversion → busy=0, bcd=000; a following load p=200 → bcd=12'h200.
REQ-039 Free-running scan → an sequence 1110,1101,1011,1111, each held 4 cycles, repeating; unchanged through a conversion.
